// File: rtl/stopwatch_input_conditioner_if.sv
// ============================================================================
// Module      : stopwatch_input_conditioner_if
// Description : Bundle of raw button inputs and conditioned clock/pulse
//               outputs exchanged between the input conditioner (master)
//               and its environment (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stopwatch_input_conditioner_if;
  logic btn_r;  // raw reset button, asynchronous, bouncing, active-high
  logic btn_p;  // raw pause/start button, asynchronous, bouncing, active-high
  logic c_clk;  // divided count clock
  logic d_clk;  // divided display/FSM clock
  logic R;      // one d_clk period reset request
  logic P;      // one d_clk period pause/start request

  // Conditioner side: samples buttons, drives clocks and pulses.
  modport master (
    input  btn_r,
    input  btn_p,
    output c_clk,
    output d_clk,
    output R,
    output P
  );

  // Environment side: drives buttons, consumes clocks and pulses.
  modport slave (
    output btn_r,
    output btn_p,
    input  c_clk,
    input  d_clk,
    input  R,
    input  P
  );
endinterface

`default_nettype wire

// File: rtl/stopwatch_input_conditioner.sv
// ============================================================================
// Module      : stopwatch_input_conditioner
// Description : Derives the count clock (c_clk) and display/FSM clock (d_clk)
//               from the board clock, and turns the raw reset/pause buttons
//               into synchronized, debounced R/P pulses that last exactly one
//               d_clk period and are centred on a d_clk rising edge.
//               Optional feature macro: STOPWATCH_LONGPRESS_RESET_EN
//               (holding pause for LP_TICKS d_clk periods injects one R).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_input_conditioner #(
  parameter int C_DIV    = 500_000,   // clk cycles per c_clk half-period
  parameter int D_DIV    = 50_000,    // clk cycles per d_clk half-period
  parameter int DB_CNT   = 1_000_000, // stable cycles before a level is accepted
  parameter int LP_TICKS = 2000       // d_clk periods of held pause -> reset
) (
  input  wire logic                      clk,
  input  wire logic                      rst_n,
  stopwatch_input_conditioner_if.master  bus
);

  // --------------------------------------------------------------------------
  // Widths and terminal counts
  // --------------------------------------------------------------------------
  localparam int C_W  = (C_DIV  > 1) ? $clog2(C_DIV)  : 1;
  localparam int D_W  = (D_DIV  > 1) ? $clog2(D_DIV)  : 1;
  localparam int DB_W = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

  localparam logic [C_W-1:0]  C_TERM  = C_W'(C_DIV - 1);
  localparam logic [D_W-1:0]  D_TERM  = D_W'(D_DIV - 1);
  localparam logic [DB_W-1:0] DB_TERM = DB_W'(DB_CNT - 1);

  // Button index into the per-button arrays.
  localparam int BTN_R = 0;
  localparam int BTN_P = 1;

  // Pulse FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [C_W-1:0]  c_cnt_q, c_cnt_d;
  logic            c_clk_q, c_clk_d;
  logic [D_W-1:0]  d_cnt_q, d_cnt_d;
  logic            d_clk_q, d_clk_d;
  logic            d_fall;

  logic [1:0]      sync1_q, sync1_d;
  logic [1:0]      sync2_q, sync2_d;

  logic [1:0]      db_q, db_d;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];
  logic [1:0]      db_rise;

  logic            lp_inject;
  logic            r_req, p_req;

  logic [1:0]      r_st_q, r_st_d;
  logic [1:0]      p_st_q, p_st_d;
  logic            r_out_q, r_out_d;
  logic            p_out_q, p_out_d;

  // --------------------------------------------------------------------------
  // Clock dividers
  // --------------------------------------------------------------------------
  // Free-running half-period counters; each output toggles at terminal count.
  always_comb begin
    c_cnt_d = c_cnt_q + C_W'(1);
    c_clk_d = c_clk_q;
    if (c_cnt_q == C_TERM) begin
      c_cnt_d = '0;
      c_clk_d = ~c_clk_q;
    end

    d_cnt_d = d_cnt_q + D_W'(1);
    d_clk_d = d_clk_q;
    if (d_cnt_q == D_TERM) begin
      d_cnt_d = '0;
      d_clk_d = ~d_clk_q;
    end
  end

  // The edge on which d_clk goes 1->0; pulses start and end here so that
  // they straddle exactly one d_clk rising edge.
  assign d_fall = (d_cnt_q == D_TERM) && d_clk_q;

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_cnt_q <= '0;
      c_clk_q <= 1'b0;
      d_cnt_q <= '0;
      d_clk_q <= 1'b0;
    end else begin
      c_cnt_q <= c_cnt_d;
      c_clk_q <= c_clk_d;
      d_cnt_q <= d_cnt_d;
      d_clk_q <= d_clk_d;
    end
  end

  // --------------------------------------------------------------------------
  // Two-flop synchronizers for the asynchronous buttons
  // --------------------------------------------------------------------------
  // Next-state of the synchronizer chain.
  always_comb begin
    sync1_d          = sync1_q;
    sync1_d[BTN_R]   = bus.btn_r;
    sync1_d[BTN_P]   = bus.btn_p;
    sync2_d          = sync1_q;
  end

  // Synchronizer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // --------------------------------------------------------------------------
  // Debouncers
  // --------------------------------------------------------------------------
  // A new level is accepted only after DB_CNT consecutive differing cycles;
  // any agreeing cycle restarts the count so short glitches are discarded.
  always_comb begin
    db_d    = db_q;
    db_rise = '0;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_TERM) begin
          db_d[i]     = sync2_q[i];
          db_cnt_d[i] = '0;
          db_rise[i]  = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Debouncer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      db_q <= db_d;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Long-press reset injection
  // --------------------------------------------------------------------------
`ifdef STOPWATCH_LONGPRESS_RESET_EN
  localparam int LP_W = $clog2(LP_TICKS + 1);
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(LP_TICKS);

  logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;

  // Count d_clk periods of held pause; saturation at LP_MAX guarantees a
  // single injection per hold until the button is released.
  always_comb begin
    lp_cnt_d  = lp_cnt_q;
    lp_inject = 1'b0;
    if (!db_q[BTN_P]) begin
      lp_cnt_d = '0;
    end else if (d_fall && (lp_cnt_q != LP_MAX)) begin
      lp_cnt_d = lp_cnt_q + LP_W'(1);
      if (lp_cnt_q == (LP_MAX - LP_W'(1))) begin
        lp_inject = 1'b1;
      end
    end
  end

  // Long-press counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lp_cnt_q <= '0;
    end else begin
      lp_cnt_q <= lp_cnt_d;
    end
  end
`else
  // Without the feature a held pause never turns into a reset.
  assign lp_inject = 1'b0;
`endif

  // Only rising edges of the accepted level generate requests.
  assign r_req = db_rise[BTN_R] | lp_inject;
  assign p_req = db_rise[BTN_P];

  // --------------------------------------------------------------------------
  // Pulse FSMs
  // --------------------------------------------------------------------------
  // IDLE -> ARMED on request, ARMED -> HOLD and HOLD -> IDLE on d_fall.
  // A reset request wins over pause: it blocks a simultaneous pause request
  // and cancels an armed one, but lets a pause already in HOLD finish.
  always_comb begin
    r_st_d = r_st_q;
    case (r_st_q)
      ST_IDLE:  if (r_req)  r_st_d = ST_ARMED;
      ST_ARMED: if (d_fall) r_st_d = ST_HOLD;
      ST_HOLD:  if (d_fall) r_st_d = ST_IDLE;
      default:              r_st_d = ST_IDLE;
    endcase

    p_st_d = p_st_q;
    case (p_st_q)
      ST_IDLE: begin
        if (p_req && !r_req) p_st_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (r_req)       p_st_d = ST_IDLE;
        else if (d_fall) p_st_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (d_fall) p_st_d = ST_IDLE;
      end
      default: p_st_d = ST_IDLE;
    endcase

    r_out_d = (r_st_d == ST_HOLD);
    p_out_d = (p_st_d == ST_HOLD);
  end

  // FSM and registered output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st_q  <= ST_IDLE;
      p_st_q  <= ST_IDLE;
      r_out_q <= 1'b0;
      p_out_q <= 1'b0;
    end else begin
      r_st_q  <= r_st_d;
      p_st_q  <= p_st_d;
      r_out_q <= r_out_d;
      p_out_q <= p_out_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all driven straight from flops
  // --------------------------------------------------------------------------
  assign bus.c_clk = c_clk_q;
  assign bus.d_clk = d_clk_q;
  assign bus.R     = r_out_q;
  assign bus.P     = p_out_q;

endmodule

`default_nettype wire
